// File: rtl/timer_controller.sv
// Run/pause/done sequencer for the two-mode timer: owns the MSB/LSB count,
// latches mode and limit at start, and flags the terminal count.
module timer_controller #(
  parameter int unsigned MODE_A_LIMIT = 99,
  parameter int unsigned SEC_WRAP     = 59
) (
  input  logic       CLK_1Hz,
  input  logic       ResetN,
  input  logic       Start,
  input  logic       Pause,
  input  logic       Clear,
  input  logic       ModeSel,
  input  logic [2:0] TimeControl,
  output logic [7:0] MSB,
  output logic [7:0] LSB,
  output logic       ModeActive,
  output logic [2:0] LimitActive,
  output logic       Running,
  output logic       Stopped
);

  localparam int unsigned CW = 8;
  localparam int unsigned LW = 3;

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   msb_nxt, lsb_nxt, inc_msb, inc_lsb;
  logic            mode_nxt;
  logic [LW-1:0]   lim_nxt;
  logic [LW:0]     lim_plus1;
  logic            terminal;

  // One count step and the terminal test on the post-increment value
  always_comb begin
    lim_plus1 = (LW+1)'(LimitActive) + (LW+1)'(1);
    inc_msb   = MSB;
    inc_lsb   = LSB;
    terminal  = 1'b0;
    if (ModeActive) begin
      if (LSB == CW'(SEC_WRAP)) begin
        inc_lsb = '0;
        inc_msb = MSB + CW'(1);
      end else begin
        inc_lsb = LSB + CW'(1);
      end
      terminal = (inc_msb == CW'(lim_plus1)) && (inc_lsb == CW'(SEC_WRAP));
    end else begin
      inc_msb  = MSB + CW'(1);
      inc_lsb  = '0;
      terminal = (inc_msb == CW'(MODE_A_LIMIT));
    end
  end

  // Next state and next register values; Clear > Pause > Start
  always_comb begin
    state_nxt = state;
    msb_nxt   = MSB;
    lsb_nxt   = LSB;
    mode_nxt  = ModeActive;
    lim_nxt   = LimitActive;
    if (Clear) begin
      state_nxt = IDLE;
      msb_nxt   = '0;
      lsb_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          msb_nxt = '0;
          lsb_nxt = '0;
          if (Start && !Pause) begin
            state_nxt = RUN;
            mode_nxt  = ModeSel;
            lim_nxt   = TimeControl;
          end
        end
        RUN: begin
          if (Pause) begin
            state_nxt = PAUSED;
          end else begin
            msb_nxt = inc_msb;
            lsb_nxt = inc_lsb;
            if (terminal) state_nxt = DONE;
          end
        end
        PAUSED: begin
          if (Start && !Pause) state_nxt = RUN;
        end
        DONE: begin
          state_nxt = DONE;
        end
        default: begin
          state_nxt = IDLE;
          msb_nxt   = '0;
          lsb_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK_1Hz) begin
    if (!ResetN) begin
      state       <= IDLE;
      MSB         <= '0;
      LSB         <= '0;
      ModeActive  <= 1'b0;
      LimitActive <= '0;
      Running     <= 1'b0;
      Stopped     <= 1'b0;
    end else begin
      state       <= state_nxt;
      MSB         <= msb_nxt;
      LSB         <= lsb_nxt;
      ModeActive  <= mode_nxt;
      LimitActive <= lim_nxt;
      Running     <= (state_nxt == RUN);
      Stopped     <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_timer_controller.sv
// Scoreboard bench for timer_controller: elapsed-seconds reference model feeds
// an expected-output queue that a separate monitor drains once per clock.
module tb_timer_controller;

  localparam int unsigned MODE_A_LIMIT = 99;
  localparam int unsigned SEC_WRAP     = 59;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, pause = 1'b0, clear = 1'b0, mode_sel = 1'b0;
  logic [2:0] time_ctl = 3'd0;
  logic [7:0] msb, lsb;
  logic       mode_act, running, stopped;
  logic [2:0] lim_act;

  typedef struct packed {
    logic [7:0] msb;
    logic [7:0] lsb;
    logic       mode;
    logic [2:0] lim;
    logic       running;
    logic       stopped;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_edge = 0;

  // Reference model: total elapsed seconds plus a run phase
  int   m_phase = M_IDLE;
  int   m_elapsed = 0;
  bit   m_mode = 1'b0;
  int   m_lim = 0;
  bit   cur_ms = 1'b0;
  bit [2:0] cur_tc = 3'd0;

  timer_controller #(.MODE_A_LIMIT(MODE_A_LIMIT), .SEC_WRAP(SEC_WRAP)) dut (
    .CLK_1Hz    (clk),
    .ResetN     (rst_n),
    .Start      (start),
    .Pause      (pause),
    .Clear      (clear),
    .ModeSel    (mode_sel),
    .TimeControl(time_ctl),
    .MSB        (msb),
    .LSB        (lsb),
    .ModeActive (mode_act),
    .LimitActive(lim_act),
    .Running    (running),
    .Stopped    (stopped)
  );

  always #5 clk = ~clk;

  function automatic int term_secs();
    if (m_mode) return (m_lim + 1) * int'(SEC_WRAP + 1) + int'(SEC_WRAP);
    return int'(MODE_A_LIMIT);
  endfunction

  function automatic obs_t model_out();
    obs_t o;
    o.msb     = m_mode ? 8'(m_elapsed / int'(SEC_WRAP + 1)) : 8'(m_elapsed);
    o.lsb     = m_mode ? 8'(m_elapsed % int'(SEC_WRAP + 1)) : 8'd0;
    o.mode    = m_mode;
    o.lim     = 3'(m_lim);
    o.running = (m_phase == M_RUN);
    o.stopped = (m_phase == M_DONE);
    return o;
  endfunction

  task automatic step(input bit rn, input bit st, input bit pa, input bit cl,
                      input bit ms, input bit [2:0] tc);
    @(negedge clk);
    rst_n = rn; start = st; pause = pa; clear = cl; mode_sel = ms; time_ctl = tc;
    if (!rn) begin
      m_phase = M_IDLE; m_elapsed = 0; m_mode = 1'b0; m_lim = 0;
    end else if (cl) begin
      m_phase = M_IDLE; m_elapsed = 0;
    end else begin
      case (m_phase)
        M_IDLE:   if (st && !pa) begin m_phase = M_RUN; m_mode = ms; m_lim = int'(tc); end
        M_RUN: begin
          if (pa) m_phase = M_PAUSED;
          else begin
            m_elapsed++;
            if (m_elapsed == term_secs()) m_phase = M_DONE;
          end
        end
        M_PAUSED: if (st && !pa) m_phase = M_RUN;
        default: ;
      endcase
    end
    exp_q.push_back(model_out());
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, cur_ms, cur_tc);
  endtask

  task automatic go(input bit ms, input bit [2:0] tc);
    cur_ms = ms; cur_tc = tc;
    step(1'b1, 1'b1, 1'b0, 1'b0, ms, tc);
  endtask

  task automatic do_clear();
    step(1'b1, 1'b0, 1'b0, 1'b1, cur_ms, cur_tc);
  endtask

  // Monitor: one registered output set per edge, checked 1 time unit later
  always @(posedge clk) begin
    #1;
    n_edge++;
    if (exp_q.size() > 0) begin
      obs_t e, a;
      e = exp_q.pop_front();
      a = '{msb, lsb, mode_act, lim_act, running, stopped};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL edge%0d outputs: got msb=%0d lsb=%0d mode=%0d lim=%0d run=%0d stop=%0d, want msb=%0d lsb=%0d mode=%0d lim=%0d run=%0d stop=%0d",
                 n_edge, a.msb, a.lsb, a.mode, a.lim, a.running, a.stopped,
                 e.msb, e.lsb, e.mode, e.lim, e.running, e.stopped);
      end
    end
  end

  initial begin
    // Reset, then reset mid-count
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd5);
    go(1'b0, 3'd0);
    idle(5);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    idle(3);
    // Mode A full run, hold, clear
    go(1'b0, 3'd0);
    idle(109);
    do_clear();
    // Mode B wrap and terminal at 1:59
    go(1'b1, 3'd0);
    idle(125);
    do_clear();
    // Pause with Start on the same edge, then resume
    go(1'b0, 3'd0);
    idle(10);
    step(1'b1, 1'b1, 1'b1, 1'b0, cur_ms, cur_tc);
    idle(3);
    step(1'b1, 1'b1, 1'b0, 1'b0, cur_ms, cur_tc);
    idle(2);
    do_clear();
    // Latching: inputs changed during RUN must not matter; ends at 8:59
    go(1'b1, 3'd7);
    cur_ms = 1'b0; cur_tc = 3'd2;
    idle(542);
    do_clear();
    // Terminal vs Pause collision
    go(1'b0, 3'd0);
    idle(98);
    step(1'b1, 1'b0, 1'b1, 1'b0, cur_ms, cur_tc);
    idle(1);
    step(1'b1, 1'b1, 1'b0, 1'b0, cur_ms, cur_tc);
    idle(2);
    step(1'b1, 1'b1, 1'b1, 1'b0, cur_ms, cur_tc);
    do_clear();
    // Randomized traffic
    for (int i = 0; i < 6000; i++) begin
      bit rn, st, pa, cl;
      rn = ($urandom_range(0, 1499) != 0);
      cl = ($urandom_range(0, 399) == 0);
      pa = ($urandom_range(0, 59) == 0);
      st = ($urandom_range(0, 9) == 0);
      cur_ms = 1'($urandom_range(0, 1));
      cur_tc = 3'($urandom_range(0, 7));
      step(rn, st, pa, cl, cur_ms, cur_tc);
    end
    // Drain check: every expectation must have been consumed
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/timer_controller.md
# timer_controller

Sequencing controller for the two-mode timer datapath. Owns the MSB/LSB count registers and the run/stop state that the flasher and display decode. It accepts start, pause and clear requests and latches mode and time limit at start. It advances the count once per 1 Hz clock and asserts `Stopped` when the mode's terminal value is reached.

## Interface

**Parameters**
- `MODE_A_LIMIT`, default 99: terminal MSB value in Mode A.
- `SEC_WRAP`, default 59: last LSB value before wrap in Mode B.

**Ports**
- `CLK_1Hz`, input, 1: the only clock; one rising edge per second.
- `ResetN`, input, 1: reset is synchronous and active-low.
- `Start`, input, 1: start/resume request, sampled each edge.
- `Pause`, input, 1: pause request, sampled each edge.
- `Clear`, input, 1: return to idle with zeroed count, sampled each edge.
- `ModeSel`, input, 1: 0 = Mode A (seconds 0..99 in MSB), 1 = Mode B (MSB minutes, LSB seconds).
- `TimeControl`, input, 3: Mode B limit; the run ends at minute `TimeControl+1`.
- `MSB`, output, 8: count high register, unsigned binary.
- `LSB`, output, 8: count low register, unsigned binary; always 0 in Mode A.
- `ModeActive`, output, 1: mode latched at start; feeds the flasher's mode input.
- `LimitActive`, output, 3: `TimeControl` latched at start; feeds the flasher.
- `Running`, output, 1: 1 only in RUN.
- `Stopped`, output, 1: 1 only in DONE.

## Operation

**States:** IDLE, RUN, PAUSED, DONE. All outputs are registered.

**Request priority on any edge:** `Clear` > `Pause` > `Start`.

**IDLE**
- `MSB` = `LSB` = 0.
- `Start` latches `ModeSel` into `ModeActive` and `TimeControl` into `LimitActive`, then moves to RUN. The count stays 0 on that edge.

**RUN**
- On each edge with no `Clear` or `Pause`, the count advances by one step.
- Mode A: `MSB` increments and `LSB` stays 0.
- Mode B: `LSB` increments. At `SEC_WRAP`, `LSB` wraps to 0 and `MSB` increments.
- Terminal check is on the post-increment value:
  - Mode A: `MSB == MODE_A_LIMIT`.
  - Mode B: `MSB == LimitActive+1` and `LSB == SEC_WRAP`.
- When the post-increment value is terminal, the state moves to DONE on the same edge.
- `Pause` moves to PAUSED. There is no increment on that edge.
- `Start` in RUN is ignored.

**PAUSED**
- The count holds.
- `Start` returns to RUN with no increment on that edge.
- Mode and limit are not re-latched.

**DONE**
- The count holds the terminal value and `Stopped` = 1.
- `Start` and `Pause` are ignored. Only `Clear` or reset leaves DONE.

**Clear (any state):** next state IDLE, `MSB` = `LSB` = 0. `ModeActive` and `LimitActive` hold their values.

**Input changes:** changes to `ModeSel` or `TimeControl` outside IDLE have no effect.

**Widths:** `LimitActive+1` is formed at 4 bits and compared zero-extended to `MSB`. The Mode B maximum is 8:59. The increment never exceeds 8 bits.

## Timing

**Reset:**
- Taken on any edge with `ResetN` = 0, regardless of other inputs or state (including mid-count and DONE).
- Result: state IDLE; `MSB`, `LSB`, `ModeActive`, `LimitActive`, `Running`, `Stopped` all 0.

**Start latency:**
- `Start` at edge k: `Running` = 1 after k.
- First increment at k+1; `MSB`/`LSB` show 1 after k+1.

**Pause latency:** `Pause` at edge k freezes the count from k onward; `Running` = 0 after k.

**Terminal detection:** `Stopped` rises on the same edge the terminal value is loaded. There are no extra counts after that.

**Simultaneous events:**
- Terminal increment coincident with `Pause`: `Pause` wins. There is no increment and no DONE.
- Coincident with `Clear`: `Clear` wins.

**Requests:** `Start`, `Pause` and `Clear` are level-sampled once per edge; a request must be held until the edge. Holding `Start` through DONE does not restart.

## Test plan

1. **Reset mid-count.** Reset, then `Start` in Mode A and run 5 edges (`MSB` = 5). Drive `ResetN` = 0 for one edge → all outputs 0 after that edge; state IDLE; a subsequent `Start` is required to count.
2. **Mode A full run.** `ModeSel` = 0, `Start`, no further input.
   - After 99 further edges: `MSB` = 99 and `Stopped` = 1.
   - 10 more edges: `MSB` stays 99.
   - `Clear`: `MSB` = 0 and `Stopped` = 0.
3. **Mode B wrap and terminal.** `ModeSel` = 1, `TimeControl` = 0, `Start`.
   - After edge 60: `MSB` = 1, `LSB` = 0.
   - After edge 119: `MSB` = 1, `LSB` = 59, `Stopped` = 1.
   - Further edges: values hold.
4. **Pause/resume and priority.**
   - Mode A, run to `MSB` = 10. Assert `Pause` with `Start` on the same edge → PAUSED, `MSB` = 10.
   - 3 idle edges → `MSB` = 10.
   - `Start` → `MSB` = 10 on that edge, 11 after the next.
5. **Latching.** `ModeSel` = 1, `TimeControl` = 7, `Start`. Flip `ModeSel` to 0 and `TimeControl` to 2 during RUN → `ModeActive` = 1, `LimitActive` = 7. Stop occurs at `MSB` = 8, `LSB` = 59.
6. **Terminal vs Pause collision.** Mode A at `MSB` = 98. Assert `Pause` on the next edge → `MSB` = 98, `Stopped` = 0. `Start` → `MSB` = 99 and `Stopped` = 1 one edge later.
